// File: rtl/fdd_track_cache_ctrl.sv
// Floppy track-buffer sequencer: flushes a modified track to SD and loads the
// newly selected track, one 512 B sector at a time, stalling the CPU meanwhile.
module fdd_track_cache_ctrl #(
  parameter int SECS  = 13,
  parameter int TRK_W = 6
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [TRK_W-1:0] track,
  input  logic             disk_we,
  input  logic             img_mounted,
  input  logic             img_present,
  input  logic             img_readonly,
  input  logic             sd_ack,
  output logic [31:0]      sd_lba,
  output logic             sd_rd,
  output logic             sd_wr,
  output logic [3:0]       track_sec,
  output logic             cpu_wait,
  output logic             dirty
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_XFER, RD_REQ, RD_XFER} state_t;

  localparam logic [9:0] SECS_W = 10'(SECS);
  localparam logic [3:0] LAST   = 4'(SECS - 1);

  state_t           r_state, w_next;
  logic [TRK_W-1:0] r_cur_track;
  logic [3:0]       r_track_sec;
  logic             r_dirty, r_valid, r_abort, r_ack_d;

  logic w_rise, w_fall, w_last, w_need, w_kill;
  logic w_ld_wr, w_ld_rd, w_inc, w_rd_done, w_abort;
  logic [9:0] w_prod;

  assign w_rise = sd_ack & ~r_ack_d;
  assign w_fall = ~sd_ack & r_ack_d;
  assign w_last = (r_track_sec == LAST);
  assign w_need = img_present & (~r_valid | (track != r_cur_track));
  // A mount (now or earlier in this transfer) cancels the remaining sectors.
  assign w_kill = img_mounted | r_abort;

  // Next state and per-cycle datapath actions.
  always_comb begin
    w_next    = r_state;
    w_ld_wr   = 1'b0;
    w_ld_rd   = 1'b0;
    w_inc     = 1'b0;
    w_rd_done = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!img_mounted && w_need) begin
          if (r_dirty && !img_readonly) begin
            w_next  = WR_REQ;
            w_ld_wr = 1'b1;
          end else begin
            w_next  = RD_REQ;
            w_ld_rd = 1'b1;
          end
        end
      end
      WR_REQ, RD_REQ: begin
        if (w_kill && !sd_ack) begin
          w_next  = IDLE;
          w_abort = 1'b1;
        end else if (w_rise) begin
          w_next = (r_state == WR_REQ) ? WR_XFER : RD_XFER;
        end
      end
      WR_XFER: begin
        if (w_fall) begin
          if (w_kill) begin
            w_next  = IDLE;
            w_abort = 1'b1;
          end else if (w_last) begin
            w_next  = RD_REQ;
            w_ld_rd = 1'b1;
          end else begin
            w_next = WR_REQ;
            w_inc  = 1'b1;
          end
        end
      end
      RD_XFER: begin
        if (w_fall) begin
          if (w_kill) begin
            w_next  = IDLE;
            w_abort = 1'b1;
          end else if (w_last) begin
            w_next    = IDLE;
            w_rd_done = 1'b1;
          end else begin
            w_next = RD_REQ;
            w_inc  = 1'b1;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Ack history is kept through reset so an in-flight ack cannot look like a new rise.
  always_ff @(posedge clk_sys) r_ack_d <= sd_ack;

  // State register plus track/sector/dirty/valid bookkeeping.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cur_track <= '0;
      r_track_sec <= '0;
      r_dirty     <= 1'b0;
      r_valid     <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_ld_wr) r_track_sec <= '0;
      if (w_inc)   r_track_sec <= r_track_sec + 4'd1;
      if (w_ld_rd) begin
        r_cur_track <= track;
        r_track_sec <= '0;
        r_dirty     <= 1'b0;
        r_valid     <= 1'b0;
      end
      if (w_rd_done) r_valid <= 1'b1;
      if (w_abort) begin
        r_dirty <= 1'b0;
        r_valid <= 1'b0;
        r_abort <= 1'b0;
      end else if (img_mounted && r_state != IDLE) begin
        r_abort <= 1'b1;
      end
      if (r_state == IDLE) begin
        if (img_mounted) begin
          r_dirty <= 1'b0;
          r_valid <= 1'b0;
        end else if (disk_we && r_valid && !img_readonly && !w_ld_rd) begin
          r_dirty <= 1'b1;
        end
      end
    end
  end

  // Requests drop combinationally on the ack and whenever an abort is due.
  assign sd_wr     = (r_state == WR_REQ) & ~sd_ack & ~w_kill;
  assign sd_rd     = (r_state == RD_REQ) & ~sd_ack & ~w_kill;
  assign w_prod    = SECS_W * 10'(r_cur_track);
  assign sd_lba    = 32'(w_prod) + 32'(r_track_sec);
  assign track_sec = r_track_sec;
  assign cpu_wait  = (r_state != IDLE);
  assign dirty     = r_dirty;

endmodule

// File: tb/tb_fdd_track_cache_ctrl.sv
// Directed bench: a scripted SD responder pops expected sector requests from a
// scoreboard queue on each ack rise; phases cover load, flush, read-only,
// track change while busy, mount abort and reset mid-transfer.
module tb_fdd_track_cache_ctrl;
  logic        clk_sys = 1'b0;
  logic        reset, disk_we, img_mounted, img_present, img_readonly, sd_ack;
  logic [5:0]  track;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, cpu_wait, dirty;
  logic [3:0]  track_sec;

  typedef struct {
    logic        wr;
    logic [31:0] lba;
    logic [3:0]  sec;
  } req_t;

  req_t sbq[$];
  int   n_cmp = 0, n_err = 0;
  int   wr_cnt = 0, wr_base = 0;
  int   rs_cnt = 0;
  bit   rs_busy = 0, resp_en = 1;

  fdd_track_cache_ctrl #(.SECS(13), .TRK_W(6)) dut (
    .clk_sys(clk_sys), .reset(reset), .track(track), .disk_we(disk_we),
    .img_mounted(img_mounted), .img_present(img_present),
    .img_readonly(img_readonly), .sd_ack(sd_ack), .sd_lba(sd_lba),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .track_sec(track_sec),
    .cpu_wait(cpu_wait), .dirty(dirty)
  );

  always #35 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_seq(input logic wr, input int base, input int n);
    req_t e;
    for (int i = 0; i < n; i++) begin
      e.wr = wr; e.lba = 32'(base + i); e.sec = 4'(i);
      sbq.push_back(e);
    end
  endtask

  // One clock; also plays the SD side: ack 2 cycles after a request, hold 4.
  task automatic tick();
    req_t e;
    @(posedge clk_sys); #1;
    chk("rd_wr_excl", 32'(sd_rd & sd_wr), 0);
    if (sd_wr) wr_cnt++;
    if (rs_busy) begin
      rs_cnt++;
      if (rs_cnt == 1) chk("req_drop_on_ack", 32'({sd_rd, sd_wr}), 0);
      if (rs_cnt == 4) begin
        sd_ack = 1'b0; rs_busy = 0; rs_cnt = 0;
      end
    end else if (resp_en && !sd_ack && (sd_rd || sd_wr)) begin
      rs_cnt++;
      if (rs_cnt == 2) begin
        rs_cnt = 0;
        if (sbq.size() == 0) begin
          chk("unexpected_req", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("req_wr", 32'(sd_wr), 32'(e.wr));
          chk("req_lba", sd_lba, e.lba);
          chk("req_sec", 32'(track_sec), 32'(e.sec));
        end
        sd_ack = 1'b1; rs_busy = 1;
      end
    end else begin
      rs_cnt = 0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    repeat (2) tick();
    while ((sbq.size() != 0 || cpu_wait || rs_busy) && n < 3000) begin
      tick(); n++;
    end
    if (n >= 3000) chk({tag, "_timeout"}, 1, 0);
    chk({tag, "_queue_left"}, 32'(sbq.size()), 0);
  endtask

  task automatic pulse_we();
    disk_we = 1'b1; tick(); disk_we = 1'b0; tick();
  endtask

  initial begin
    int n;
    reset = 1; disk_we = 0; img_mounted = 0; img_present = 0;
    img_readonly = 0; sd_ack = 0; track = 0;
    repeat (3) tick();
    chk("rst_lba", sd_lba, 0);
    chk("rst_rdwr", 32'({sd_rd, sd_wr}), 0);
    chk("rst_sec", 32'(track_sec), 0);
    chk("rst_wait", 32'(cpu_wait), 0);
    chk("rst_dirty", 32'(dirty), 0);
    reset = 0;
    repeat (4) tick();
    chk("no_img_idle", 32'({cpu_wait, sd_rd}), 0);

    // 1: initial load of track 0
    wr_base = wr_cnt;
    push_seq(0, 0, 13);
    img_present = 1;
    wait_idle("t1");
    chk("t1_no_wr", 32'(wr_cnt - wr_base), 0);
    repeat (5) tick();
    chk("t1_stays_idle", 32'(cpu_wait), 0);

    // 2: load 3, dirty it, move to 4 -> flush then load
    track = 3; push_seq(0, 39, 13);
    wait_idle("t2a");
    pulse_we();
    chk("t2_dirty_set", 32'(dirty), 1);
    track = 4; push_seq(1, 39, 13); push_seq(0, 52, 13);
    wait_idle("t2b");
    chk("t2_dirty_clr", 32'(dirty), 0);

    // 3: read-only image never gets dirty or flushed
    img_readonly = 1; wr_base = wr_cnt;
    track = 3; push_seq(0, 39, 13);
    wait_idle("t3a");
    pulse_we();
    chk("t3_ro_dirty", 32'(dirty), 0);
    track = 4; push_seq(0, 52, 13);
    wait_idle("t3b");
    chk("t3_no_wr", 32'(wr_cnt - wr_base), 0);
    img_readonly = 0;

    // 4: 5 -> 6 -> 7 while loading 6
    track = 5; push_seq(0, 65, 13);
    wait_idle("t4a");
    track = 6; push_seq(0, 78, 13); push_seq(0, 91, 13);
    repeat (6) tick();
    track = 7;
    n = 0;
    while (sbq.size() > 13 && n < 3000) begin tick(); n++; end
    while (cpu_wait && n < 3000) begin tick(); n++; end
    if (n >= 3000) chk("t4_timeout", 1, 0);
    tick();
    chk("t4_restart_wait", 32'(cpu_wait), 1);
    chk("t4_restart_rd", 32'(sd_rd), 1);
    chk("t4_restart_lba", sd_lba, 91);
    wait_idle("t4b");

    // 5: mount during flush of sector 4
    pulse_we();
    chk("t5_dirty_set", 32'(dirty), 1);
    track = 8; push_seq(1, 91, 5);
    n = 0;
    while (!(rs_busy && track_sec == 4) && n < 3000) begin tick(); n++; end
    if (n >= 3000) chk("t5_timeout", 1, 0);
    img_mounted = 1; tick(); img_mounted = 0;
    wr_base = wr_cnt;
    push_seq(0, 104, 13);
    wait_idle("t5");
    chk("t5_no_wr_after", 32'(wr_cnt - wr_base), 0);
    chk("t5_dirty_clr", 32'(dirty), 0);

    // 6: reset with read pending and ack high
    resp_en = 0;
    track = 9;
    n = 0;
    while (!sd_rd && n < 100) begin tick(); n++; end
    if (n >= 100) chk("t6_timeout", 1, 0);
    chk("t6_first_lba", sd_lba, 117);
    sd_ack = 1; tick();
    reset = 1; tick();
    chk("t6_rd_drop", 32'(sd_rd), 0);
    chk("t6_wait_drop", 32'(cpu_wait), 0);
    reset = 0; tick(); tick();
    chk("t6_ack_held_rd", 32'(sd_rd), 0);
    sd_ack = 0; tick();
    chk("t6_sec_no_inc", 32'(track_sec), 0);
    chk("t6_rd_again", 32'(sd_rd), 1);
    push_seq(0, 117, 13);
    resp_en = 1;
    wait_idle("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
